// File: rtl/max7219_pkg.sv
// Shared constants and state encoding for the MAX7219 command sequencer.
package max7219_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_DISPTEST  = 8'h0F;

  localparam int INIT_WORDS = 5;
  localparam int NUM_ROWS   = 8;

  typedef enum logic [2:0] {
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } word_state_t;

endpackage

// File: rtl/max7219_frame_buf.sv
// Double-buffered 8x8 frame: user writes go to shadow, swap copies all of
// shadow into active in a single cycle.
module max7219_frame_buf
  import max7219_pkg::*;
(
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic       swap,
  input  logic [2:0] raddr,
  output logic [7:0] rdata
);

  logic [NUM_ROWS-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_ROWS-1:0][7:0] active_q, active_d;

  // A write in the swap cycle lands in shadow only; the copy uses the old shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (swap) active_d = shadow_q;
    if (we) shadow_d[waddr] = wdata;
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign rdata = active_q[raddr];

endmodule

// File: rtl/max7219_sequencer.sv
// MAX7219 command sequencer: power-up init words, then a continuous row refresh
// from the active frame, one word at a time over a start/busy handshake.
module max7219_sequencer
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY_RST = 4'h8,
  parameter logic [2:0] SCAN_LIMIT    = 3'd7,
  parameter int         GAP_CYCLES    = 4,
  parameter int         ACK_TIMEOUT   = 15
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       row_we,
  input  logic [2:0] row_addr,
  input  logic [7:0] row_data,
  input  logic       frame_commit,
  input  logic [3:0] intensity,
  input  logic       tx_busy,
  output logic       tx_str,
  output logic [7:0] tx_addr,
  output logic [7:0] tx_data,
  output logic       init_done,
  output logic       commit_pending,
  output logic       frame_ack,
  output logic       err_timeout
);

  word_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic [2:0]  row_idx_q, row_idx_d;
  logic        boundary_q, boundary_d;
  logic        run_q;
  logic [3:0]  last_int_q, last_int_d;
  logic [7:0]  tx_addr_q, tx_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        init_done_q, init_done_d;
  logic        pending_q, pending_d;
  logic        frame_ack_q, frame_ack_d;
  logic        err_q, err_d;
  logic        swap;
  logic [7:0]  row_rdata;

  max7219_frame_buf u_frame_buf (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .we      (row_we),
    .waddr   (row_addr),
    .wdata   (row_data),
    .swap    (swap),
    .raddr   (row_idx_q),
    .rdata   (row_rdata)
  );

  // Boundary priority: pending intensity word, then the swap (its own cycle so
  // row 0 reads the new active frame), then row 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    row_idx_d   = row_idx_q;
    boundary_d  = boundary_q;
    last_int_d  = last_int_q;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    swap        = 1'b0;

    unique case (state_q)
      ST_SELECT: begin
        if (!run_q) begin
          state_d = ST_SELECT;
        end else if (!init_done_q) begin
          unique case (init_idx_q)
            3'd0: begin tx_addr_d = REG_DISPTEST;  tx_data_d = 8'h00; end
            3'd1: begin tx_addr_d = REG_DECODE;    tx_data_d = 8'h00; end
            3'd2: begin tx_addr_d = REG_INTENSITY; tx_data_d = {4'h0, INTENSITY_RST}; end
            3'd3: begin tx_addr_d = REG_SCANLIMIT; tx_data_d = {5'b0, SCAN_LIMIT}; end
            default: begin tx_addr_d = REG_SHUTDOWN; tx_data_d = 8'h01; end
          endcase
          init_idx_d = init_idx_q + 3'd1;
          state_d    = ST_ISSUE;
        end else if (boundary_q && (intensity != last_int_q)) begin
          tx_addr_d  = REG_INTENSITY;
          tx_data_d  = {4'h0, intensity};
          last_int_d = intensity;
          state_d    = ST_ISSUE;
        end else if (boundary_q && pending_q) begin
          swap = 1'b1;
        end else begin
          tx_addr_d  = REG_DIGIT0 + {5'b0, row_idx_q};
          tx_data_d  = row_rdata;
          row_idx_d  = row_idx_q + 3'd1;
          boundary_d = (row_idx_q == 3'd7);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = '0;
        if (!tx_busy) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == 8'(GAP_CYCLES - 1)) begin
          state_d     = ST_SELECT;
          init_done_d = init_done_q | (init_idx_q == 3'(INIT_WORDS));
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_SELECT;
    endcase
  end

  // A commit in the swap cycle stays pending so a same-cycle row write is not lost.
  always_comb begin
    pending_d   = frame_commit | (pending_q & ~swap);
    frame_ack_d = swap;
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= ST_SELECT;
      cnt_q       <= '0;
      init_idx_q  <= '0;
      row_idx_q   <= '0;
      boundary_q  <= 1'b1;
      run_q       <= 1'b0;
      last_int_q  <= INTENSITY_RST;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      init_done_q <= 1'b0;
      pending_q   <= 1'b0;
      frame_ack_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      row_idx_q   <= row_idx_d;
      boundary_q  <= boundary_d;
      run_q       <= 1'b1;
      last_int_q  <= last_int_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
      frame_ack_q <= frame_ack_d;
      err_q       <= err_d;
    end
  end

  assign tx_str         = (state_q == ST_ISSUE);
  assign tx_addr        = tx_addr_q;
  assign tx_data        = tx_data_q;
  assign init_done      = init_done_q;
  assign commit_pending = pending_q;
  assign frame_ack      = frame_ack_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench for max7219_sequencer with a behavioural serializer model
// (busy for 50 cycles after each accepted start).
module tb_max7219_sequencer;

  logic       sys_clk;
  logic       rst_n;
  logic       row_we;
  logic [2:0] row_addr;
  logic [7:0] row_data;
  logic       frame_commit;
  logic [3:0] intensity;
  logic       tx_busy;
  logic       tx_str;
  logic [7:0] tx_addr;
  logic [7:0] tx_data;
  logic       init_done;
  logic       commit_pending;
  logic       frame_ack;
  logic       err_timeout;

  int total = 0;
  int bad = 0;
  int ack_count = 0;
  int ack_pos = 0;
  logic [15:0] words [$];
  logic prev_busy = 1'b0;
  logic model_en = 1'b1;
  int busy_cnt;

  logic [7:0]  pat1 [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 8'h42, 8'h24, 8'h18};
  logic [7:0]  pat2 [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'hF7};
  logic [15:0] init_exp [5] = '{16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};

  max7219_sequencer dut (
    .sys_clk        (sys_clk),
    ._rst           (rst_n),
    .row_we         (row_we),
    .row_addr       (row_addr),
    .row_data       (row_data),
    .frame_commit   (frame_commit),
    .intensity      (intensity),
    .tx_busy        (tx_busy),
    .tx_str         (tx_str),
    .tx_addr        (tx_addr),
    .tx_data        (tx_data),
    .init_done      (init_done),
    .commit_pending (commit_pending),
    .frame_ack      (frame_ack),
    .err_timeout    (err_timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Serializer model shares the reset and aborts on it.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_str && model_en) busy_cnt <= 50;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(posedge sys_clk) begin
    #1;
    if (rst_n) begin
      if (tx_str) begin
        words.push_back({tx_addr, tx_data});
        total++;
        if (tx_busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL str_while_busy got busy=%b want 0", tx_busy);
        end
      end
      if (prev_busy && !tx_busy) begin
        total++;
        if ({tx_addr, tx_data} !== words[$]) begin
          bad++;
          $display("[TB] FAIL word_stable got=%h want=%h", {tx_addr, tx_data}, words[$]);
        end
      end
      if (frame_ack) begin
        ack_count++;
        ack_pos = words.size();
      end
      prev_busy = tx_busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic wait_words(input int n, output bit ok);
    int budget;
    budget = 80 * (n - words.size()) + 200;
    while (words.size() < n && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    ok = (words.size() >= n);
  endtask

  task automatic wait_new_addr(input logic [7:0] a, output bit ok);
    int sz;
    int budget;
    sz = words.size();
    budget = 1500;
    ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge sys_clk);
      budget--;
      if (words.size() > sz && words[$][15:8] == a) ok = 1'b1;
    end
  endtask

  task automatic write_row(input int r, input logic [7:0] d, input logic commit);
    @(negedge sys_clk);
    row_we = 1'b1;
    row_addr = 3'(r);
    row_data = d;
    frame_commit = commit;
    @(negedge sys_clk);
    row_we = 1'b0;
    frame_commit = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({tx_str, tx_addr, tx_data, init_done, commit_pending, frame_ack, err_timeout} !== 21'h0) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h want=000000",
               {tx_str, tx_addr, tx_data, init_done, commit_pending, frame_ack, err_timeout});
    end
    rst_n = 1'b1;
    n = 0;
    while (!tx_str && n < 10) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("[TB] FAIL first_str_latency got=%0d want=2", n);
    end
  endtask

  task automatic test_init();
    bit ok;
    wait_words(5, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL init_words got=%0d words want=5", words.size());
      return;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (words[i] !== init_exp[i]) begin
        bad++;
        $display("[TB] FAIL init_word%0d got=%h want=%h", i, words[i], init_exp[i]);
      end
    end
    total++;
    if (init_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL init_done_early got=%b want=0", init_done);
    end
    wait_words(6, ok);
    total++;
    if (!ok || init_done !== 1'b1 || words[5] !== 16'h0100) begin
      bad++;
      $display("[TB] FAIL first_row got ok=%b done=%b word=%h want 1/1/0100",
               ok, init_done, ok ? words[5] : 16'hxxxx);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int acks0;
    int n;
    int p;
    for (int k = 0; k < 8; k++) write_row(k, pat1[k], 1'b0);
    acks0 = ack_count;
    @(negedge sys_clk);
    frame_commit = 1'b1;
    @(negedge sys_clk);
    frame_commit = 1'b0;
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("[TB] FAIL commit_pending_rise got=%b want=1", commit_pending);
    end
    n = 0;
    while (ack_count == acks0 && n < 1500) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (ack_count != acks0 + 1 || commit_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL frame_ack got acks=%0d pending=%b want acks=%0d pending=0",
               ack_count - acks0, commit_pending, 1);
      return;
    end
    p = ack_pos;
    wait_words(p + 8, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL frame_words got=%0d want=%0d", words.size(), p + 8);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (words[p+k] !== {8'(k + 1), pat1[k]}) begin
        bad++;
        $display("[TB] FAIL frame_row%0d got=%h want=%h", k, words[p+k], {8'(k + 1), pat1[k]});
      end
    end
  endtask

  task automatic test_commit_mid();
    bit ok;
    int acks0;
    int acks1;
    int n;
    int p;
    int s;
    logic [7:0] exp;
    wait_new_addr(8'h04, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL mid_sync got=timeout want=row3 word");
      return;
    end
    for (int k = 0; k < 6; k++) write_row(k, pat2[k], 1'b0);
    acks0 = ack_count;
    s = words.size();
    write_row(6, pat2[6], 1'b1);
    write_row(7, pat2[7], 1'b1);
    n = 0;
    while (ack_count == acks0 && n < 1500) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (ack_count != acks0 + 1) begin
      bad++;
      $display("[TB] FAIL mid_ack got=%0d want=1", ack_count - acks0);
      return;
    end
    p = ack_pos;
    for (int i = s; i < p; i++) begin
      total++;
      if (words[i][15:8] < 8'h01 || words[i][15:8] > 8'h08 ||
          words[i][7:0] !== pat1[words[i][15:8] - 8'h01]) begin
        bad++;
        $display("[TB] FAIL old_frame idx=%0d got=%h want old row data", i, words[i]);
      end
    end
    wait_words(p + 17, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL mid_words got=%0d want=%0d", words.size(), p + 17);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      exp = pat2[k];
      total++;
      if (words[p+k] !== {8'(k + 1), exp}) begin
        bad++;
        $display("[TB] FAIL new_row%0d got=%h want=%h", k, words[p+k], {8'(k + 1), exp});
      end
    end
    acks1 = ack_count;
    total++;
    if (acks1 != acks0 + 1) begin
      bad++;
      $display("[TB] FAIL commit_absorb got acks=%0d want=1", acks1 - acks0);
    end
  endtask

  task automatic test_intensity();
    bit ok;
    int s;
    int cnt0a;
    int first01;
    wait_new_addr(8'h03, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL int_sync got=timeout want=row2 word");
      return;
    end
    s = words.size();
    @(negedge sys_clk);
    intensity = 4'h3;
    wait_words(s + 20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL int_words got=%0d want=%0d", words.size(), s + 20);
      return;
    end
    cnt0a = 0;
    first01 = -1;
    for (int i = s; i < s + 20; i++) begin
      if (words[i][15:8] == 8'h0A) cnt0a++;
      if (first01 < 0 && words[i][15:8] == 8'h01) first01 = i;
    end
    total++;
    if (cnt0a != 1) begin
      bad++;
      $display("[TB] FAIL int_count got=%0d want=1", cnt0a);
    end
    total++;
    if (first01 <= s || words[first01-1] !== 16'h0A03) begin
      bad++;
      $display("[TB] FAIL int_before_row0 got idx=%0d word=%h want 0A03 before 01xx",
               first01, first01 > s ? words[first01-1] : 16'hxxxx);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] a;
    logic [7:0] d;
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_before got=%b want=0", err_timeout);
    end
    n = 0;
    while (!tx_busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    model_en = 1'b0;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!tx_str && n < 200);
    total++;
    if (!tx_str) begin
      bad++;
      $display("[TB] FAIL to_str got=timeout want=tx_str");
      model_en = 1'b1;
      return;
    end
    a = tx_addr;
    d = tx_data;
    for (int k = 1; k <= 16; k++) begin
      @(negedge sys_clk);
      if (k == 14) begin
        total++;
        if (err_timeout !== 1'b0) begin
          bad++;
          $display("[TB] FAIL err_early got=%b want=0", err_timeout);
        end
      end
    end
    total++;
    if (err_timeout !== 1'b1 || tx_str !== 1'b1 || tx_addr !== a || tx_data !== d) begin
      bad++;
      $display("[TB] FAIL reissue got err=%b str=%b word=%h want 1/1/%h",
               err_timeout, tx_str, {tx_addr, tx_data}, {a, d});
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    int s;
    n = 0;
    while (!(tx_str && tx_addr == 8'h05) && n < 1500) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (!(tx_str && tx_addr == 8'h05)) begin
      bad++;
      $display("[TB] FAIL rst_sync got=timeout want=row4 word");
      return;
    end
    repeat (10) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_str, tx_addr, tx_data, init_done, commit_pending, frame_ack, err_timeout} !== 21'h0) begin
      bad++;
      $display("[TB] FAIL midreset_values got=%h want=000000",
               {tx_str, tx_addr, tx_data, init_done, commit_pending, frame_ack, err_timeout});
    end
    repeat (3) @(negedge sys_clk);
    s = words.size();
    rst_n = 1'b1;
    wait_words(s + 7, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL restart_words got=%0d want=%0d", words.size(), s + 7);
      return;
    end
    total++;
    if (words[s] !== 16'h0F00 || words[s+4] !== 16'h0C01) begin
      bad++;
      $display("[TB] FAIL restart_init got=%h,%h want=0F00,0C01", words[s], words[s+4]);
    end
    total++;
    if (words[s+5] !== 16'h0A03 || words[s+6] !== 16'h0100) begin
      bad++;
      $display("[TB] FAIL restart_pass got=%h,%h want=0A03,0100", words[s+5], words[s+6]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    row_we = 1'b0;
    row_addr = 3'd0;
    row_data = 8'h00;
    frame_commit = 1'b0;
    intensity = 4'h8;
    test_reset();
    test_init();
    test_frame();
    test_commit_mid();
    test_intensity();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
